flash_loader: RTL and testbench

FLASH_LOADER -- requirements
Module: flash_loader

---
 rtl/flash_loader.sv | 159 +++++++++++++++
 tb/tb_flash_loader.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_loader.sv
// flash_loader: copies WORD_COUNT 16-bit flash words into WORD_COUNT/2 32-bit
// RAM words. Two flash reads are packed per RAM write: the first word goes to
// ram_wdata[15:0] and the second to ram_wdata[31:16].
//
// Parameters:
//   WORD_COUNT  number of flash words to copy (even, >= 2)
//   FLASH_BASE  first flash word address read
//   RAM_BASE    first RAM word address written
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   start            one-cycle pulse; ignored while busy
//   flash_req        one-cycle read request, flash_rd_addr valid with it
//   flash_rd_valid   one-cycle pulse qualifying flash_rd_data
//   ram_we           write strobe, held with ram_addr/ram_wdata until ram_ack
//   busy/done/error  copy in progress / completed / aborted on timeout
//
// Handshake semantics: flash_req is a fire-and-forget pulse; the matching
// flash_rd_valid is accepted only in RD_WAIT. ram_we acts as valid and ram_ack
// as ready: the write completes in the first cycle where both are high,
// including the first cycle of ram_we; ram_ack seen at any other time is ignored.
//
// Optional build macro FLASH_LOADER_TIMEOUT_EN: adds an 8-bit RD_WAIT timeout
// that moves the FSM to ERROR. Without it RD_WAIT waits forever and error is 0.

module flash_loader #(
  parameter int          WORD_COUNT = 1024,
  parameter logic [22:0] FLASH_BASE = 23'h000000,
  parameter logic [19:0] RAM_BASE   = 20'h00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        flash_req,
  output logic [22:0] flash_rd_addr,
  input  logic        flash_rd_valid,
  input  logic [15:0] flash_rd_data,
  output logic        ram_we,
  output logic [19:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic        ram_ack,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    RAM_WR  = 3'd3,
    DONE    = 3'd4,
    ERROR   = 3'd5
  } state_t;

  localparam logic [22:0] WORD_COUNT_W = 23'(WORD_COUNT);

  state_t      state_q, state_d;
  logic [22:0] index_q, index_d;
  logic        half_q, half_d;
  logic [22:0] index_half;

`ifdef FLASH_LOADER_TIMEOUT_EN
  logic [7:0]  tmo_cnt_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and index/half bookkeeping
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    half_d  = half_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = RD_REQ;
          index_d = '0;
          half_d  = 1'b0;
        end
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: begin
        if (flash_rd_valid) begin
          index_d = index_q + 23'd1;
          half_d  = ~half_q;
          state_d = half_q ? RAM_WR : RD_REQ;
        end
`ifdef FLASH_LOADER_TIMEOUT_EN
        // Counter becomes 255 on this edge; a valid in the same cycle wins.
        else if (tmo_cnt_q == 8'd254) begin
          state_d = ERROR;
        end
`endif
      end
      RAM_WR: begin
        if (ram_ack) state_d = (index_q == WORD_COUNT_W) ? DONE : RD_REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // index_d already counts the word just read, so the RAM word is index/2 - 1.
  assign index_half = index_d >> 1;

  // Datapath: index, half flag, registered addresses and packed write data
  always_ff @(posedge clk) begin
    if (rst) begin
      index_q       <= '0;
      half_q        <= 1'b0;
      flash_rd_addr <= '0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
    end else begin
      index_q <= index_d;
      half_q  <= half_d;
      if (state_d == RD_REQ) flash_rd_addr <= FLASH_BASE + index_d;
      if (state_q == RD_WAIT && flash_rd_valid) begin
        if (half_q) ram_wdata[31:16] <= flash_rd_data;
        else        ram_wdata[15:0]  <= flash_rd_data;
      end
      if (state_q == RD_WAIT && state_d == RAM_WR)
        ram_addr <= RAM_BASE + index_half[19:0] - 20'd1;
    end
  end

`ifdef FLASH_LOADER_TIMEOUT_EN
  // RD_WAIT is only ever entered from RD_REQ, so clearing there clears on entry.
  always_ff @(posedge clk) begin
    if (rst)                                       tmo_cnt_q <= '0;
    else if (state_q == RD_REQ)                    tmo_cnt_q <= '0;
    else if (state_q == RD_WAIT && !flash_rd_valid) tmo_cnt_q <= tmo_cnt_q + 8'd1;
  end
`endif

  // Outputs decoded from state
  always_comb begin
    flash_req = 1'b0;
    ram_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    case (state_q)
      RD_REQ:  begin flash_req = 1'b1; busy = 1'b1; end
      RD_WAIT: busy = 1'b1;
      RAM_WR:  begin ram_we = 1'b1; busy = 1'b1; end
      DONE:    done = 1'b1;
`ifdef FLASH_LOADER_TIMEOUT_EN
      ERROR:   error = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_flash_loader.sv
module tb_flash_loader;
  localparam logic [22:0] FB = 23'h10;
  localparam logic [19:0] RB = 20'h40;

  logic        clk, rst, start;
  logic        flash_req, flash_rd_valid, ram_we, ram_ack, busy, done, error;
  logic [22:0] flash_rd_addr;
  logic [15:0] flash_rd_data;
  logic [19:0] ram_addr;
  logic [31:0] ram_wdata;

  // second instance for the minimum WORD_COUNT
  logic        start2, flash_req2, flash_rd_valid2, ram_we2, ram_ack2, busy2, done2, error2;
  logic [22:0] flash_rd_addr2;
  logic [15:0] flash_rd_data2;
  logic [19:0] ram_addr2;
  logic [31:0] ram_wdata2;

  int pass_cnt = 0;
  int total_cnt = 0;

  // stimulus / model controls
  logic        flash_en, stray_valid_en, stray_ack;
  int          ack_delay;
  int          we_cnt;
  logic        req_d1;
  logic [22:0] addr_d1;
  logic [15:0] flash_mem [0:3];

  // scoreboard
  logic [22:0] fexp_q[$];
  logic [51:0] wexp_q[$];
  int          writes;
  int          we_len;
  logic [51:0] held;

  // wc2 monitor
  logic        req2_d1;
  logic [22:0] addr2_d1;
  int          reads2, writes2;
  logic [51:0] last_w2;

  flash_loader #(.WORD_COUNT(4), .FLASH_BASE(23'h10), .RAM_BASE(20'h40)) dut (
    .clk(clk), .rst(rst), .start(start),
    .flash_req(flash_req), .flash_rd_addr(flash_rd_addr),
    .flash_rd_valid(flash_rd_valid), .flash_rd_data(flash_rd_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_ack(ram_ack),
    .busy(busy), .done(done), .error(error)
  );

  flash_loader #(.WORD_COUNT(2), .FLASH_BASE(23'h100), .RAM_BASE(20'h7)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .flash_req(flash_req2), .flash_rd_addr(flash_rd_addr2),
    .flash_rd_valid(flash_rd_valid2), .flash_rd_data(flash_rd_data2),
    .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .ram_ack(ram_ack2),
    .busy(busy2), .done(done2), .error(error2)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flash responder: 2-cycle latency, plus optional stray valids outside RD_WAIT
  always @(posedge clk) begin
    if (rst) begin
      req_d1         <= 1'b0;
      addr_d1        <= '0;
      flash_rd_valid <= 1'b0;
      flash_rd_data  <= '0;
      we_cnt         <= 0;
    end else begin
      req_d1  <= flash_req && flash_en;
      addr_d1 <= flash_rd_addr;
      if (req_d1) begin
        flash_rd_valid <= 1'b1;
        flash_rd_data  <= flash_mem[2'(addr_d1 - FB)];
      end else if (stray_valid_en && (ram_we || !busy)) begin
        flash_rd_valid <= 1'b1;
        flash_rd_data  <= 16'hDEAD;
      end else begin
        flash_rd_valid <= 1'b0;
      end
      we_cnt <= (ram_we && !ram_ack) ? we_cnt + 1 : 0;
    end
  end

  assign ram_ack = (ram_we && we_cnt == ack_delay) || stray_ack;

  // responder for the WORD_COUNT=2 instance
  always @(posedge clk) begin
    if (rst) begin
      req2_d1         <= 1'b0;
      addr2_d1        <= '0;
      flash_rd_valid2 <= 1'b0;
      flash_rd_data2  <= '0;
    end else begin
      req2_d1         <= flash_req2;
      addr2_d1        <= flash_rd_addr2;
      flash_rd_valid2 <= req2_d1;
      flash_rd_data2  <= {addr2_d1[7:0], 8'hA5};
    end
  end

  assign ram_ack2 = ram_we2;

  always @(negedge clk) begin
    if (!rst) begin
      if (flash_req2) reads2++;
      if (ram_we2 && ram_ack2) begin
        writes2++;
        last_w2 = {ram_addr2, ram_wdata2};
      end
    end
  end

  // scoreboard monitor for the main instance
  always @(negedge clk) begin
    logic [22:0] fe;
    logic [51:0] we;
    if (rst) begin
      we_len = 0;
    end else begin
      if (flash_req) begin
        total_cnt++;
        if (fexp_q.size() == 0) begin
          $display("FAIL flash_addr: unexpected request at addr %h", flash_rd_addr);
        end else begin
          fe = fexp_q.pop_front();
          if (flash_rd_addr !== fe)
            $display("FAIL flash_addr: got %h expected %h", flash_rd_addr, fe);
          else pass_cnt++;
        end
      end
      if (ram_we) begin
        if (we_len == 0) begin
          held = {ram_addr, ram_wdata};
        end else begin
          total_cnt++;
          if ({ram_addr, ram_wdata} !== held)
            $display("FAIL ram_hold: got %h expected %h", {ram_addr, ram_wdata}, held);
          else pass_cnt++;
        end
        we_len++;
        if (ram_ack) begin
          total_cnt++;
          if (we_len !== ack_delay + 1)
            $display("FAIL ram_we_len: got %0d expected %0d", we_len, ack_delay + 1);
          else pass_cnt++;
          total_cnt++;
          if (wexp_q.size() == 0) begin
            $display("FAIL ram_write: unexpected write %h", {ram_addr, ram_wdata});
          end else begin
            we = wexp_q.pop_front();
            if ({ram_addr, ram_wdata} !== we)
              $display("FAIL ram_write: got %h expected %h", {ram_addr, ram_wdata}, we);
            else pass_cnt++;
          end
          writes++;
          we_len = 0;
        end
      end
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fexp_q.delete();
    wexp_q.delete();
  endtask

  task automatic push_copy();
    for (int i = 0; i < 4; i++) fexp_q.push_back(FB + 23'(i));
    wexp_q.push_back({RB, 32'h22221111});
    wexp_q.push_back({RB + 20'd1, 32'h44443333});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (done !== 1'b1) $display("FAIL %s_done: done=%b after %0d cycles, expected 1", name, done, n);
    else pass_cnt++;
  endtask

  task automatic finish_checks(input string name);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL %s_busy: got %b expected 0", name, busy);
    else pass_cnt++;
    total_cnt++;
    if (writes !== 2) $display("FAIL %s_writes: got %0d expected 2", name, writes);
    else pass_cnt++;
    total_cnt++;
    if (fexp_q.size() != 0 || wexp_q.size() != 0)
      $display("FAIL %s_drain: %0d reads and %0d writes still expected", name, fexp_q.size(), wexp_q.size());
    else pass_cnt++;
  endtask

  task automatic run_copy(input string name);
    writes = 0;
    push_copy();
    pulse_start();
    total_cnt++;
    if (busy !== 1'b1 || flash_req !== 1'b1)
      $display("FAIL %s_start: busy=%b flash_req=%b expected 1/1", name, busy, flash_req);
    else pass_cnt++;
    wait_done(500, name);
    finish_checks(name);
  endtask

  task automatic check_all_zero(input string name);
    total_cnt++;
    if ({flash_req, ram_we, busy, done, error} !== 5'b0)
      $display("FAIL %s_flags: req/we/busy/done/error=%b expected 00000", name,
               {flash_req, ram_we, busy, done, error});
    else pass_cnt++;
    total_cnt++;
    if (flash_rd_addr !== 23'h0) $display("FAIL %s_flash_addr: got %h expected 0", name, flash_rd_addr);
    else pass_cnt++;
    total_cnt++;
    if (ram_addr !== 20'h0) $display("FAIL %s_ram_addr: got %h expected 0", name, ram_addr);
    else pass_cnt++;
    total_cnt++;
    if (ram_wdata !== 32'h0) $display("FAIL %s_ram_wdata: got %h expected 0", name, ram_wdata);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    check_all_zero("reset");
  endtask

  task automatic test_basic();
    ack_delay = 0;
    run_copy("basic");
  endtask

  task automatic test_back_to_back();
    ack_delay = 0;
    run_copy("b2b");
  endtask

  task automatic test_ack_delay();
    ack_delay = 5;
    run_copy("ack_delay");
    ack_delay = 0;
  endtask

  task automatic test_busy_start_stray();
    int n = 0;
    ack_delay      = 3;
    stray_valid_en = 1'b1;
    writes         = 0;
    push_copy();
    pulse_start();
    while (done !== 1'b1 && n < 500) begin
      start = (($urandom_range(0, 3) == 0) && busy === 1'b1);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    total_cnt++;
    if (done !== 1'b1) $display("FAIL busy_start_done: done=%b expected 1", done);
    else pass_cnt++;
    finish_checks("busy_start");
    stray_valid_en = 1'b0;
    ack_delay      = 0;
  endtask

  task automatic test_stray_idle();
    stray_valid_en = 1'b1;
    stray_ack      = 1'b1;
    cyc(4);
    total_cnt++;
    if (done !== 1'b1 || busy !== 1'b0 || ram_we !== 1'b0)
      $display("FAIL stray_idle: done/busy/ram_we=%b expected 100", {done, busy, ram_we});
    else pass_cnt++;
    stray_ack      = 1'b0;
    stray_valid_en = 1'b0;
    cyc(2);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int seen = 0;
    ack_delay = 0;
    writes    = 0;
    push_copy();
    pulse_start();
    if (flash_req === 1'b1) seen++;
    while (seen < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (flash_req === 1'b1) seen++;
    end
    total_cnt++;
    if (seen != 3) $display("FAIL reset_mid_reach: saw %0d reads expected 3", seen);
    else pass_cnt++;
    @(negedge clk);  // now in RD_WAIT of the third read
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset_mid");
    rst = 1'b0;
    fexp_q.delete();
    wexp_q.delete();
    cyc(6);
    total_cnt++;
    if (busy !== 1'b0 || ram_we !== 1'b0)
      $display("FAIL reset_mid_quiet: busy=%b ram_we=%b expected 0/0", busy, ram_we);
    else pass_cnt++;
    run_copy("after_reset");
  endtask

  task automatic test_timeout();
    int n = 0;
    flash_en = 1'b0;
    writes   = 0;
    fexp_q.push_back(FB);
    pulse_start();
`ifdef FLASH_LOADER_TIMEOUT_EN
    while (error !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (n !== 256) $display("FAIL timeout_len: error after %0d cycles expected 256", n);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || error !== 1'b1) $display("FAIL timeout_flags: busy/error=%b expected 01", {busy, error});
    else pass_cnt++;
    flash_en = 1'b1;
    run_copy("retry");
    total_cnt++;
    if (error !== 1'b0) $display("FAIL retry_error: got %b expected 0", error);
    else pass_cnt++;
`else
    cyc(300);
    total_cnt++;
    if (busy !== 1'b1 || error !== 1'b0) $display("FAIL no_timeout: busy/error=%b expected 10", {busy, error});
    else pass_cnt++;
    flash_en = 1'b1;
    do_reset();
`endif
  endtask

  task automatic test_wc2();
    int n = 0;
    reads2  = 0;
    writes2 = 0;
    start2  = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    while (done2 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (done2 !== 1'b1 || busy2 !== 1'b0) $display("FAIL wc2_done: done/busy=%b expected 10", {done2, busy2});
    else pass_cnt++;
    total_cnt++;
    if (reads2 !== 2 || writes2 !== 1) $display("FAIL wc2_count: reads=%0d writes=%0d expected 2/1", reads2, writes2);
    else pass_cnt++;
    total_cnt++;
    if (last_w2 !== {20'h7, 32'h01A500A5}) $display("FAIL wc2_data: got %h expected %h", last_w2, {20'h7, 32'h01A500A5});
    else pass_cnt++;
  endtask

  initial begin
    flash_mem[0] = 16'h1111;
    flash_mem[1] = 16'h2222;
    flash_mem[2] = 16'h3333;
    flash_mem[3] = 16'h4444;
    rst            = 1'b1;
    start          = 1'b0;
    start2         = 1'b0;
    flash_en       = 1'b1;
    stray_valid_en = 1'b0;
    stray_ack      = 1'b0;
    ack_delay      = 0;
    writes         = 0;
    reads2         = 0;
    writes2        = 0;
    last_w2        = '0;
    do_reset();
    test_reset();
    test_basic();
    test_back_to_back();
    test_ack_delay();
    test_busy_start_stray();
    test_stray_idle();
    test_reset_mid();
    test_timeout();
    test_wc2();
    cyc(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
